// File: rtl/miller_decoder_if.sv
// Decoder-side bundle: SoF enable and pause level in, decoded bytes and frame status out.
// Latency: none, wires only.
// Backpressure: none; every output is a one-clock strobe that the consumer must take.
interface miller_decoder_if;
    logic       in_enable;
    logic       in_pause;
    logic [7:0] out_data;
    logic [3:0] out_bit_cnt;
    logic       out_data_valid;
    logic       out_parity_err;
    logic       out_eof;
    logic       out_code_err;
    logic       out_busy;

    // Upstream side (SoF detector / pause detector) and downstream consumer.
    modport master (
        output in_enable,
        output in_pause,
        input  out_data,
        input  out_bit_cnt,
        input  out_data_valid,
        input  out_parity_err,
        input  out_eof,
        input  out_code_err,
        input  out_busy
    );

    // The decoder itself.
    modport slave (
        input  in_enable,
        input  in_pause,
        output out_data,
        output out_bit_cnt,
        output out_data_valid,
        output out_parity_err,
        output out_eof,
        output out_code_err,
        output out_busy
    );
endinterface

// File: rtl/miller_decoder.sv
// Modified-Miller (106 kb/s) symbol/bit decoder with LSB-first byte assembly, odd parity and EoF detect.
// Latency: strobes are registered and appear the clock after the ETU end that decides them.
// Backpressure: none; data/eof/code-error are one-clock strobes with no stall path.
module miller_decoder #(
    parameter int ETU_CLKS  = 32,
    parameter int PHASE_W   = 5,
    parameter int HALF      = 16,
    parameter int SOF_PHASE = 16
) (
    input  logic               in_clk,
    input  logic               in_PoR,
    miller_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(ETU_CLKS - 1);
    localparam logic [PHASE_W-1:0] PH_HALF  = PHASE_W'(HALF);
    localparam logic [PHASE_W-1:0] PH_SOF   = PHASE_W'(SOF_PHASE);
    // The clock carrying a pause edge is itself phase 0 (or HALF), so the
    // register takes the phase that follows it.
    localparam logic [PHASE_W-1:0] PH_SYNC1 = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_SYNC2 = PHASE_W'(HALF + 1);

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 prev_bit_q, prev_bit_d;
    logic                 flag_first_q, flag_first_d;
    logic                 flag_second_q, flag_second_d;
    logic                 sof_skip_q, sof_skip_d;
    logic                 pause_q;

    logic [7:0]           data_q, data_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 eof_q, eof_d;
    logic                 cerr_q, cerr_d;

    logic                 pause_edge;
    logic                 hit_first;
    logic                 hit_second;
    logic                 f1;
    logic                 f2;
    logic                 dec_have;
    logic                 dec_bit;

    assign pause_edge = bus.in_pause & ~pause_q;
    assign hit_first  = pause_edge & (phase_q <  PH_HALF);
    assign hit_second = pause_edge & (phase_q >= PH_HALF);
    // Flags as seen at the decision clock, including an edge on that clock.
    assign f1         = flag_first_q  | hit_first;
    assign f2         = flag_second_q | hit_second;

    assign bus.out_data       = data_q;
    assign bus.out_bit_cnt    = cnt_q;
    assign bus.out_data_valid = valid_q;
    assign bus.out_parity_err = perr_q;
    assign bus.out_eof        = eof_q;
    assign bus.out_code_err   = cerr_q;
    assign bus.out_busy       = (state_q == RUN);

    // Next-state, ETU timing, symbol decision and bit assembly.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        prev_bit_d    = prev_bit_q;
        flag_first_d  = flag_first_q;
        flag_second_d = flag_second_q;
        sof_skip_d    = sof_skip_q;
        data_d        = '0;
        cnt_d         = '0;
        valid_d       = 1'b0;
        perr_d        = 1'b0;
        eof_d         = 1'b0;
        cerr_d        = 1'b0;
        dec_have      = 1'b0;
        dec_bit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_enable) begin
                    phase_d       = PH_SOF;
                    prev_bit_d    = 1'b0;
                    bit_idx_d     = '0;
                    shreg_d       = '0;
                    flag_first_d  = 1'b0;
                    flag_second_d = 1'b0;
                    sof_skip_d    = 1'b1;
                    state_d       = RUN;
                end
            end

            RUN: begin
                if (!bus.in_enable) begin
                    // Frame abandoned upstream: drop partial data silently.
                    state_d = IDLE;
                end else begin
                    flag_first_d  = f1;
                    flag_second_d = f2;
                    if (pause_edge) begin
                        phase_d = hit_first ? PH_SYNC1 : PH_SYNC2;
                    end else if (phase_q == PH_LAST) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end

                    if (phase_q == PH_LAST) begin
                        flag_first_d  = 1'b0;
                        flag_second_d = 1'b0;
                        if (sof_skip_q) begin
                            // This ETU end only closes the SoF symbol.
                            sof_skip_d = 1'b0;
                        end else if (f1 && f2) begin
                            cerr_d  = 1'b1;
                            eof_d   = 1'b1;
                            state_d = DONE;
                        end else if (f2) begin
                            dec_have = 1'b1;
                            dec_bit  = 1'b1;
                        end else if (f1 || prev_bit_q) begin
                            // Z, or Y following a one: both decode as zero.
                            dec_have = 1'b1;
                            dec_bit  = 1'b0;
                        end else begin
                            // Y after a zero ends the frame; flush any residual bits.
                            valid_d = (bit_idx_q != 4'd0);
                            data_d  = shreg_q;
                            cnt_d   = bit_idx_q;
                            eof_d   = 1'b1;
                            state_d = DONE;
                        end

                        if (dec_have) begin
                            prev_bit_d = dec_bit;
                            if (bit_idx_q == 4'd8) begin
                                valid_d   = 1'b1;
                                data_d    = shreg_q;
                                cnt_d     = 4'd8;
                                perr_d    = ~(^shreg_q ^ dec_bit);
                                bit_idx_d = '0;
                                shreg_d   = '0;
                            end else begin
                                shreg_d[bit_idx_q[2:0]] = dec_bit;
                                bit_idx_d = bit_idx_q + 4'd1;
                            end
                        end
                    end
                end
            end

            DONE: begin
                if (!bus.in_enable) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all updated on the falling edge of the fc/4 clock.
    always_ff @(negedge in_clk or negedge in_PoR) begin
        if (!in_PoR) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            prev_bit_q    <= 1'b0;
            flag_first_q  <= 1'b0;
            flag_second_q <= 1'b0;
            sof_skip_q    <= 1'b0;
            pause_q       <= 1'b0;
            data_q        <= '0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            perr_q        <= 1'b0;
            eof_q         <= 1'b0;
            cerr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            prev_bit_q    <= prev_bit_d;
            flag_first_q  <= flag_first_d;
            flag_second_q <= flag_second_d;
            sof_skip_q    <= sof_skip_d;
            pause_q       <= bus.in_pause;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            perr_q        <= perr_d;
            eof_q         <= eof_d;
            cerr_q        <= cerr_d;
        end
    end

endmodule

// File: tb/tb_miller_decoder.sv
// Bench for miller_decoder: frames are built from bit lists, expected strobes come from
// a bit-grouping reference model into a queue, and a monitor pops and compares them.
// Pause edges may arrive late by a few clocks; the decoder must resync on every edge.
module tb_miller_decoder;

    localparam int PRE     = 24;   // wave index at which in_enable first goes high
    localparam int PW      = 8;    // pause pulse width in clocks
    localparam int WAVE_N  = 4096;
    localparam int K_EOF   = 0;
    localparam int K_CERR  = 1;
    localparam int K_ABORT = 2;

    logic in_clk = 1'b0;
    logic in_PoR = 1'b0;

    miller_decoder_if bus();

    miller_decoder dut (
        .in_clk (in_clk),
        .in_PoR (in_PoR),
        .bus    (bus)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] cnt;
        logic       valid;
        logic       perr;
        logic       eof;
        logic       cerr;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_ev;
    int   checks = 0;
    int   errors = 0;
    logic wave [0:WAVE_N-1];
    bit   tx[$];
    int   en_stop;
    int   wave_len;
    int   cur_kind;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void mark(input int e);
        for (int k = 0; k < PW; k++) wave[e + k] = 1'b1;
    endfunction

    task automatic push_bits(input logic [7:0] v, input int n);
        for (int b = 0; b < n; b++) tx.push_back(v[b]);
    endtask

    // Turn the bit list into a pause waveform: X = edge mid-ETU, Z = edge at ETU start,
    // Y = no edge. Each edge may be late by up to jit clocks; the sender's grid follows it.
    task automatic build(input int kind, input int jit);
        int  grid;
        int  e;
        int  j;
        bit  prev;
        for (int i = 0; i < WAVE_N; i++) wave[i] = 1'b0;
        mark(PRE - 16);                       // SoF pause, seen before enable rises
        if (kind == K_EOF && tx.size() > 0 && tx[tx.size() - 1] == 1'b1)
            tx.push_back(1'b0);               // a one must be followed by a zero before EoF
        grid = PRE + 17;                      // first data ETU start
        prev = 1'b0;
        foreach (tx[i]) begin
            j = int'($urandom_range(jit, 0));
            if (tx[i]) begin
                e = grid + 16 + j; mark(e); grid = e - 16;
            end else if (!prev) begin
                e = grid + j; mark(e); grid = e;
            end
            prev = tx[i];
            grid += 32;
        end
        if (kind == K_CERR) begin
            e = grid + 4; mark(e); mark(e + 16); grid = e + 32;
        end else if (kind == K_EOF) begin
            grid += 32;                       // closing Y
        end
        en_stop  = (kind == K_ABORT) ? grid + 10 : grid + 6;
        wave_len = en_stop + 6;
        cur_kind = kind;
    endtask

    // Reference: every 9 decoded bits form a byte plus odd parity; what is left at the
    // end is a residual strobe carrying the EoF; a code error flushes everything.
    task automatic model(input int kind);
        int         n;
        int         full;
        int         r;
        logic [7:0] d;
        ev_t        ev;
        n    = tx.size();
        full = n / 9;
        for (int g = 0; g < full; g++) begin
            for (int b = 0; b < 8; b++) d[b] = tx[9 * g + b];
            ev       = '0;
            ev.data  = d;
            ev.cnt   = 4'd8;
            ev.valid = 1'b1;
            ev.perr  = ($countones({d, tx[9 * g + 8]}) % 2) == 0;
            exp_q.push_back(ev);
        end
        if (kind == K_EOF) begin
            r = n % 9;
            d = '0;
            for (int b = 0; b < r; b++) d[b] = tx[9 * full + b];
            ev       = '0;
            ev.data  = d;
            ev.cnt   = 4'(r);
            ev.valid = (r != 0);
            ev.eof   = 1'b1;
            exp_q.push_back(ev);
        end else if (kind == K_CERR) begin
            ev      = '0;
            ev.eof  = 1'b1;
            ev.cerr = 1'b1;
            exp_q.push_back(ev);
        end
    endtask

    task automatic play(input int por_at);
        for (int i = 0; i < wave_len; i++) begin
            @(posedge in_clk);
            if (i == PRE + 12) chk("busy_in_run", 32'(bus.out_busy), 32'd1);
            if (i == en_stop - 1 && cur_kind != K_ABORT)
                chk("busy_after_end", 32'(bus.out_busy), 32'd0);
            bus.in_pause  = wave[i];
            bus.in_enable = (i >= PRE && i < en_stop);
            if (i == por_at) begin
                #2;
                in_PoR        = 1'b0;
                bus.in_enable = 1'b0;
                bus.in_pause  = 1'b0;
                #1;
                chk("por_data",  32'(bus.out_data), 32'd0);
                chk("por_cnt",   32'(bus.out_bit_cnt), 32'd0);
                chk("por_valid", 32'(bus.out_data_valid), 32'd0);
                chk("por_eof",   32'(bus.out_eof), 32'd0);
                chk("por_busy",  32'(bus.out_busy), 32'd0);
                repeat (3) @(posedge in_clk);
                in_PoR = 1'b1;
                break;
            end
        end
        bus.in_enable = 1'b0;
        bus.in_pause  = 1'b0;
    endtask

    task automatic run(input int kind, input int jit, input bit por);
        build(kind, jit);
        model(kind);
        play(por ? en_stop - 1 : -1);
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge in_clk);
        chk("strobes_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) @(posedge in_clk);
        chk("busy_idle", 32'(bus.out_busy), 32'd0);
    endtask

    // Monitor: every strobe the decoder presents must match the head of the queue.
    always @(posedge in_clk) begin
        if (bus.out_data_valid || bus.out_eof || bus.out_code_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("data_valid", 32'(bus.out_data_valid), 32'(mon_ev.valid));
                chk("eof",        32'(bus.out_eof),        32'(mon_ev.eof));
                chk("code_err",   32'(bus.out_code_err),   32'(mon_ev.cerr));
                if (mon_ev.valid) begin
                    chk("data",       32'(bus.out_data),       32'(mon_ev.data));
                    chk("bit_cnt",    32'(bus.out_bit_cnt),    32'(mon_ev.cnt));
                    chk("parity_err", 32'(bus.out_parity_err), 32'(mon_ev.perr));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int kind;
        bus.in_enable = 1'b0;
        bus.in_pause  = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        chk("rst_data",       32'(bus.out_data), 32'd0);
        chk("rst_bit_cnt",    32'(bus.out_bit_cnt), 32'd0);
        chk("rst_valid",      32'(bus.out_data_valid), 32'd0);
        chk("rst_parity_err", 32'(bus.out_parity_err), 32'd0);
        chk("rst_eof",        32'(bus.out_eof), 32'd0);
        chk("rst_code_err",   32'(bus.out_code_err), 32'd0);
        chk("rst_busy",       32'(bus.out_busy), 32'd0);
        @(posedge in_clk);
        in_PoR = 1'b1;
        repeat (4) @(posedge in_clk);

        // REQA short frame
        tx.delete(); push_bits(8'h26, 7); run(K_EOF, 0, 1'b0);
        // full byte with good parity, then a one-bit residual
        tx.delete(); push_bits(8'h93, 8); tx.push_back(1'b1); run(K_EOF, 0, 1'b0);
        // same byte with bad parity
        tx.delete(); push_bits(8'h93, 8); tx.push_back(1'b0); run(K_EOF, 0, 1'b0);
        // two pause edges in one ETU
        tx.delete(); push_bits(8'h02, 2); run(K_CERR, 0, 1'b0);
        // 20 bits with edges arriving late by up to 3 clocks
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(1'($urandom_range(1, 0)));
        run(K_EOF, 3, 1'b0);
        // power-on reset mid-byte, then a clean REQA
        tx.delete(); push_bits(8'h35, 5); run(K_ABORT, 0, 1'b1);
        tx.delete(); push_bits(8'h26, 7); run(K_EOF, 0, 1'b0);
        // enable dropped mid-byte, then a clean REQA
        tx.delete(); push_bits(8'h35, 5); run(K_ABORT, 0, 1'b0);
        tx.delete(); push_bits(8'h26, 7); run(K_EOF, 0, 1'b0);
        // empty frame: EoF straight after SoF, no data strobe
        tx.delete(); run(K_EOF, 0, 1'b0);

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            tx.delete();
            n = int'($urandom_range(30, 0));
            for (int i = 0; i < n; i++) tx.push_back(1'($urandom_range(1, 0)));
            kind = ($urandom_range(3, 0) == 0) ? K_CERR : K_EOF;
            run(kind, int'($urandom_range(3, 0)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
